// File: rtl/fp_to_int.sv
// Two-stage IEEE-754 float to integer converter with valid/ready handshake.
// Define FP2INT_ROUND_EN for round-to-nearest-even; the default build truncates toward zero.
module fp_to_int #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int INT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_float,
    input  logic                           in_signed,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [INT_WIDTH-1:0]           out_int,
    output logic [1:0]                     out_flags
);

    localparam int WW   = MAN_WIDTH + INT_WIDTH + 1;
    localparam int SHW  = $clog2(INT_WIDTH);
    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;

    localparam logic [INT_WIDTH-1:0] S_MAX    = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH-1:0] S_MIN    = {1'b1, {(INT_WIDTH-1){1'b0}}};
    localparam logic [INT_WIDTH-1:0] U_MAX    = {INT_WIDTH{1'b1}};
    localparam logic [INT_WIDTH:0]   MAG_SMIN = {2'b01, {(INT_WIDTH-1){1'b0}}};

    // ---------------- unpack ----------------
    logic                   w_in_sign;
    logic [EXP_WIDTH-1:0]   w_in_exp;
    logic [MAN_WIDTH-1:0]   w_in_man;
    logic                   w_exp_ones;
    logic                   w_exp_zero;
    logic                   w_man_nz;
    logic signed [EXP_WIDTH:0] w_in_e;
    logic [EXP_WIDTH:0]     w_bias;

    assign w_in_sign  = in_float[EXP_WIDTH+MAN_WIDTH];
    assign w_in_exp   = in_float[MAN_WIDTH +: EXP_WIDTH];
    assign w_in_man   = in_float[MAN_WIDTH-1:0];
    assign w_exp_ones = &w_in_exp;
    assign w_exp_zero = ~|w_in_exp;
    assign w_man_nz   = |w_in_man;
    assign w_bias     = BIAS[EXP_WIDTH:0];
    assign w_in_e     = $signed({1'b0, w_in_exp} - w_bias);

    // ---------------- handshake ----------------
    logic w_adv;
    logic w_s1_load;
    logic r_s1_valid;
    logic r_out_valid;

    assign w_adv     = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_adv;
    assign in_ready  = w_s1_load;

    // ---------------- stage 1 registers ----------------
    logic                      r_s1_sign;
    logic                      r_s1_signed;
    logic signed [EXP_WIDTH:0] r_s1_e;
    logic [MAN_WIDTH:0]        r_s1_sig;
    logic                      r_s1_nan;
    logic                      r_s1_inf;
    logic                      r_s1_zero;
    logic                      r_s1_denorm;

    always_ff @(posedge clk) begin
        if (w_s1_load && in_valid) begin
            r_s1_sign   <= w_in_sign;
            r_s1_signed <= in_signed;
            r_s1_e      <= w_in_e;
            r_s1_sig    <= w_exp_zero ? '0 : {1'b1, w_in_man};
            r_s1_nan    <= w_exp_ones && w_man_nz;
            r_s1_inf    <= w_exp_ones && !w_man_nz;
            r_s1_zero   <= w_exp_zero && !w_man_nz;
            r_s1_denorm <= w_exp_zero && w_man_nz;
        end
    end

    // ---------------- stage 2: align, round, saturate ----------------
    logic signed [31:0]    w_e_ext;
    logic                  w_in_range;
    logic [SHW-1:0]        w_sh;
    logic [WW-1:0]         w_wide;
    logic [INT_WIDTH:0]    w_int;
    logic [MAN_WIDTH-1:0]  w_frac;
    logic [INT_WIDTH:0]    w_mag;
    logic                  w_lossy;
    logic                  w_ovf;
    logic                  w_invalid;
    logic                  w_inexact;
    logic [INT_WIDTH-1:0]  w_res;

    always_comb begin
        w_e_ext    = 32'(r_s1_e);
        w_in_range = (w_e_ext >= 0) && (w_e_ext < INT_WIDTH);
        w_sh       = w_in_range ? w_e_ext[SHW-1:0] : '0;
        // Fixed point with MAN_WIDTH fraction bits; exponent never exceeds INT_WIDTH-1 here.
        w_wide     = WW'(r_s1_sig) << w_sh;
        w_int      = w_wide[WW-1 -: INT_WIDTH+1];
        w_frac     = w_wide[MAN_WIDTH-1:0];
        w_mag      = '0;
        w_lossy    = 1'b0;
        w_ovf      = 1'b0;
        w_invalid  = 1'b0;
        w_inexact  = 1'b0;
        w_res      = '0;

        if (r_s1_nan) begin
            w_invalid = 1'b1;
            w_res     = r_s1_signed ? S_MAX : U_MAX;
        end else begin
            if (r_s1_inf || (w_e_ext >= INT_WIDTH)) begin
                w_ovf = 1'b1;
            end else if (r_s1_zero) begin
                w_mag = '0;
            end else if (r_s1_denorm) begin
                w_lossy = 1'b1;
            end else if (w_e_ext < 0) begin
                w_lossy = 1'b1;
`ifdef FP2INT_ROUND_EN
                // e=-1: guard is the hidden bit, so anything above one half rounds up.
                if (w_e_ext == -1)
                    w_mag = {{INT_WIDTH{1'b0}}, |r_s1_sig[MAN_WIDTH-1:0]};
`endif
            end else begin
                w_lossy = |w_frac;
`ifdef FP2INT_ROUND_EN
                w_mag = w_int + {{INT_WIDTH{1'b0}},
                        w_frac[MAN_WIDTH-1] & ((|w_frac[MAN_WIDTH-2:0]) | w_int[0])};
`else
                w_mag = w_int;
`endif
            end

            if (!w_ovf) begin
                if (r_s1_signed)
                    w_ovf = r_s1_sign ? (w_mag > MAG_SMIN) : (w_mag >= MAG_SMIN);
                else
                    w_ovf = r_s1_sign ? (|w_mag) : w_mag[INT_WIDTH];
            end

            if (w_ovf) begin
                w_invalid = 1'b1;
                if (r_s1_sign)
                    w_res = r_s1_signed ? S_MIN : '0;
                else
                    w_res = r_s1_signed ? S_MAX : U_MAX;
            end else begin
                w_inexact = w_lossy;
                w_res     = r_s1_sign ? -w_mag[INT_WIDTH-1:0] : w_mag[INT_WIDTH-1:0];
            end
        end
    end

    // ---------------- valid tracking and output register ----------------
    logic [INT_WIDTH-1:0] r_out_int;
    logic [1:0]           r_out_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_int   <= '0;
            r_out_flags <= '0;
        end else begin
            if (w_s1_load)
                r_s1_valid <= in_valid;
            if (w_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_int   <= w_res;
                    r_out_flags <= {w_invalid, w_inexact};
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_int   = r_out_int;
    assign out_flags = r_out_flags;

endmodule

// File: tb/tb_fp_to_int.sv
// Directed testbench for fp_to_int: conversions, saturation, latency, backpressure and reset flush.
module tb_fp_to_int;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_float;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_int;
    logic [1:0]  out_flags;

    int checks = 0;
    int errors = 0;

    fp_to_int #(.EXP_WIDTH(8), .MAN_WIDTH(23), .INT_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_float  (in_float),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operand, waits (bounded) for its result, consumes it.
    task automatic run_one(input logic [31:0] f, input logic sgn,
                           output logic [31:0] res, output logic [1:0] flg,
                           output logic timeout);
        in_valid  = 1'b1;
        in_float  = f;
        in_signed = sgn;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        timeout  = 1'b1;
        res      = '0;
        flg      = '0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                timeout = 1'b0;
                res     = out_int;
                flg     = out_flags;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_int !== 32'h0 || out_flags !== 2'b00) begin
            errors++;
            $display("FAIL reset_state got valid=%b int=%h flags=%b exp valid=0 int=0 flags=00",
                     out_valid, out_int, out_flags);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got in_ready=%b out_valid=%b exp in_ready=1 out_valid=0",
                     in_ready, out_valid);
        end
        $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_latency();
        logic v1;
        logic v2;
        logic [31:0] r2;
        logic [1:0]  f2;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_float  = 32'h3F800000;
        in_signed = 1'b1;
        tick();
        in_valid = 1'b0;
        v1 = out_valid;
        tick();
        v2 = out_valid;
        r2 = out_int;
        f2 = out_flags;
        checks++;
        if (v1 !== 1'b0 || v2 !== 1'b1 || r2 !== 32'h1 || f2 !== 2'b00) begin
            errors++;
            $display("FAIL latency got v1=%b v2=%b int=%h flags=%b exp v1=0 v2=1 int=00000001 flags=00",
                     v1, v2, r2, f2);
        end
        $display("latency: 1.0 -> %h flags=%b", r2, f2);
        tick();
    endtask

    typedef struct {
        logic [31:0] f;
        logic        sgn;
        logic [31:0] res;
        logic [1:0]  flg;
    } vec_t;

    task automatic test_vectors();
        vec_t vecs[$];
        logic [31:0] r;
        logic [1:0]  fl;
        logic        to;
        vecs.push_back('{32'h3F800000, 1'b1, 32'h00000001, 2'b00}); // 1.0
        vecs.push_back('{32'hC0200000, 1'b1, 32'hFFFFFFFE, 2'b01}); // -2.5
`ifdef FP2INT_ROUND_EN
        vecs.push_back('{32'h40600000, 1'b1, 32'h00000004, 2'b01}); // 3.5
        vecs.push_back('{32'h3FC00000, 1'b1, 32'h00000002, 2'b01}); // 1.5
`else
        vecs.push_back('{32'h40600000, 1'b1, 32'h00000003, 2'b01});
        vecs.push_back('{32'h3FC00000, 1'b1, 32'h00000001, 2'b01});
`endif
        vecs.push_back('{32'h7FC00000, 1'b1, 32'h7FFFFFFF, 2'b10}); // NaN
        vecs.push_back('{32'h7FC00000, 1'b0, 32'hFFFFFFFF, 2'b10});
        vecs.push_back('{32'hFF800000, 1'b1, 32'h80000000, 2'b10}); // -Inf
        vecs.push_back('{32'h7F800000, 1'b0, 32'hFFFFFFFF, 2'b10}); // +Inf
        vecs.push_back('{32'h4F000000, 1'b1, 32'h7FFFFFFF, 2'b10}); // 2^31
        vecs.push_back('{32'h4F000000, 1'b0, 32'h80000000, 2'b00});
        vecs.push_back('{32'hCF000000, 1'b1, 32'h80000000, 2'b00}); // -2^31
        vecs.push_back('{32'hBF800000, 1'b0, 32'h00000000, 2'b10}); // -1.0 unsigned
        vecs.push_back('{32'hBF000000, 1'b0, 32'h00000000, 2'b01}); // -0.5 unsigned
        vecs.push_back('{32'h00000000, 1'b1, 32'h00000000, 2'b00}); // +0
        vecs.push_back('{32'h00000001, 1'b1, 32'h00000000, 2'b01}); // denormal
        vecs.push_back('{32'h4F800000, 1'b0, 32'hFFFFFFFF, 2'b10}); // 2^32
        vecs.push_back('{32'h4F7FFFFF, 1'b0, 32'hFFFFFF00, 2'b00}); // just below 2^32
        vecs.push_back('{32'h4EFFFFFF, 1'b1, 32'h7FFFFF80, 2'b00}); // just below 2^31
        vecs.push_back('{32'h3F000000, 1'b1, 32'h00000000, 2'b01}); // 0.5
        vecs.push_back('{32'hC2F60000, 1'b1, 32'hFFFFFF85, 2'b00}); // -123.0
        foreach (vecs[i]) begin
            run_one(vecs[i].f, vecs[i].sgn, r, fl, to);
            checks++;
            if (to || r !== vecs[i].res || fl !== vecs[i].flg) begin
                errors++;
                $display("FAIL vec%0d f=%h signed=%b got int=%h flags=%b timeout=%b exp int=%h flags=%b",
                         i, vecs[i].f, vecs[i].sgn, r, fl, to, vecs[i].res, vecs[i].flg);
            end
            $display("vec%0d: f=%h signed=%b -> int=%h flags=%b", i, vecs[i].f, vecs[i].sgn, r, fl);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [4];
        logic        ev;
        logic [31:0] ei;
        ops[0] = 32'h3F800000;
        ops[1] = 32'h40000000;
        ops[2] = 32'h40400000;
        ops[3] = 32'h40800000;
        out_ready = 1'b1;
        in_signed = 1'b1;
        for (int c = 0; c < 8; c++) begin
            ev = (c >= 2) && (c <= 5);
            ei = 32'(c - 1);
            checks++;
            if (out_valid !== ev || (ev && out_int !== ei)) begin
                errors++;
                $display("FAIL b2b_cycle%0d got valid=%b int=%h exp valid=%b int=%h",
                         c, out_valid, out_int, ev, ei);
            end
            $display("b2b cycle%0d: valid=%b int=%h", c, out_valid, out_int);
            if (c < 4) begin
                in_valid = 1'b1;
                in_float = ops[c];
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        out_ready = 1'b0;
        in_signed = 1'b1;
        in_valid  = 1'b1;
        in_float  = 32'h3F800000;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept1 got in_ready=%b exp 1", in_ready);
        end
        tick();
        in_float = 32'h40000000;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept2 got in_ready=%b exp 1", in_ready);
        end
        tick();
        in_float = 32'h40400000;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall got in_ready=%b exp 0", in_ready);
        end
        held = out_int;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_int !== 32'h1 || held !== 32'h1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got valid=%b int=%h first=%h in_ready=%b exp valid=1 int=00000001 in_ready=0",
                     out_valid, out_int, held, in_ready);
        end
        $display("backpressure: holding int=%h in_ready=%b", out_int, in_ready);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got in_ready=%b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k < 2 && (out_valid !== 1'b1 || out_int !== 32'(k + 2))) begin
                errors++;
                $display("FAIL bp_drain%0d got valid=%b int=%h exp valid=1 int=%h",
                         k, out_valid, out_int, 32'(k + 2));
            end else if (k == 2 && out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_drain_end got valid=%b exp 0", out_valid);
            end
            $display("backpressure drain%0d: valid=%b int=%h", k, out_valid, out_int);
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] r;
        logic [1:0]  fl;
        logic        to;
        out_ready = 1'b0;
        in_signed = 1'b1;
        in_valid  = 1'b1;
        in_float  = 32'h40000000;
        tick();
        in_float = 32'h40400000;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_int !== 32'h0 || out_flags !== 2'b00) begin
            errors++;
            $display("FAIL midflight_reset got valid=%b int=%h flags=%b exp valid=0 int=0 flags=00",
                     out_valid, out_int, out_flags);
        end
        rst = 1'b0;
        tick();
        run_one(32'h3F800000, 1'b1, r, fl, to);
        checks++;
        if (to || r !== 32'h1 || fl !== 2'b00) begin
            errors++;
            $display("FAIL midflight_fresh got int=%h flags=%b timeout=%b exp int=00000001 flags=00",
                     r, fl, to);
        end
        $display("midflight reset: fresh 1.0 -> %h flags=%b", r, fl);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_float  = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
